unibus_intr_arb: RTL and testbench
==================================

Name: unibus_intr_arb

Overview:
- Processor-side end of the Unibus BR/BG interrupt protocol, the counterpart of the interrupt-requesting peripherals (line clock, serial lines, etc.).
- Samples bus requests BR7..BR4 and compares them against CPU priority.
- Issues a single bus grant on the winning level, runs the SACK/BBSY/INTR handshake, latches the interrupt vector and answers with SSYN.
- Presents the captured vector and priority level to the CPU microsequencer.

Parameters:
- DESKEW, 2, clk cycles BR must be stable and unchanged before a grant is issued.
- SSYN_DLY, 8, clk cycles from INTR sampled high to asserting SSYN (vector capture point).
- GRANT_TMO, 255, clk cycles to hold BG waiting for SACK before cancelling the grant.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-low reset
- bus_init  input  1  Unibus INIT, synchronous clear
- bus_br  input  4  [7:4] bus requests, active high
- bus_sack  input  1  selection acknowledge from device
- bus_bbsy  input  1  bus busy
- bus_intr  input  1  interrupt strobe from bus master
- bus_d  input  16  data lines (vector)
- bus_bg_out  output  4  [7:4] bus grants, at most one bit set
- bus_ssyn_out  output  1  slave sync for INTR transaction
- cpu_pri  input  3  current processor priority (PSW[7:5])
- grant_ok  input  1  CPU at instruction boundary; new grants permitted
- vec_valid  output  1  vector captured, held until vec_ack
- vec  output  16  captured vector; bits [1:0] forced 0
- vec_pri  output  3  BR level (4..7) of the accepted interrupt
- vec_ack  input  1  CPU has consumed vector

Behaviour:
- Reset (reset low) or bus_init high: state IDLE, all counters 0. bus_bg_out=0, bus_ssyn_out=0, vec_valid=0, vec=0, vec_pri=0. bus_init is applied on clk edge; reset is asynchronous.
- Winner: highest n in 7..4 with bus_br[n]=1 and n>cpu_pri. Fixed priority, BR7 highest.
- IDLE:
  - Deskew counter increments while the winner is nonzero and unchanged; it resets whenever the winner changes or is none.
  - Go to GRANT when count reaches DESKEW, grant_ok=1 and vec_valid=0.
  - On entry to GRANT: set bus_bg_out[winner]=1 and latch the level in lvl.
- GRANT:
  - Hold BG. On bus_sack=1: drop BG next edge, go to WAIT_INTR.
  - If the timeout counter reaches GRANT_TMO without SACK: drop BG, go to IDLE. No vector is produced.
  - BR dropping during GRANT does not drop BG; only SACK or timeout does.
- WAIT_INTR:
  - Wait for bus_intr=1 (device has taken BBSY and released SACK). Go to STROBE and clear the delay counter.
  - If bus_sack=0, bus_intr=0 and bus_bbsy=0 for GRANT_TMO cycles: go to IDLE (device aborted).
- STROBE:
  - Count SSYN_DLY cycles while bus_intr=1.
  - At the terminal count: latch vec={bus_d[15:2],2'b00}, vec_pri=lvl, assert bus_ssyn_out, set vec_valid. Go to HOLD.
  - bus_intr falling before the terminal count: return to IDLE, no capture.
- HOLD:
  - Keep bus_ssyn_out=1 until bus_intr=0. Drop SSYN on the following edge and go to IDLE.
- vec_valid:
  - Cleared on the edge where vec_ack=1.
  - vec and vec_pri hold their value until the next capture.
  - vec_ack while vec_valid=0 is ignored.
- While vec_valid=1, no new grant is issued, so a second interrupt waits on BR.
- cpu_pri changes while in GRANT or later: the handshake completes regardless. Comparison happens only in IDLE.
- Only one bus_bg_out bit may ever be high. A grant is never asserted in the same cycle as bus_ssyn_out.
- Counters saturate and never wrap.

Test Plan:
- Basic BR6 interrupt:
  - Stimulus: cpu_pri=0, bus_br=4'b0100, grant_ok=1.
  - Required: bus_bg_out=4'b0100 after DESKEW cycles.
  - Device SACK -> BG drops. INTR with bus_d='o100 -> SSYN after 8 cycles. vec='o100, vec_pri=6, vec_valid=1.
  - INTR drop -> SSYN drop next cycle.
- Priority masking:
  - cpu_pri=6, bus_br=4'b0100 -> no grant for 1000 cycles.
  - Raise BR7 -> bus_bg_out=4'b1000, vec_pri=7.
- Simultaneous requests:
  - bus_br=4'b0101, cpu_pri=3 -> BG6 granted first; after vec_ack, BG4 granted.
- Grant timeout:
  - BR5 asserted, SACK never asserted -> BG5 high for exactly 255 cycles, then 0; state IDLE, vec_valid stays 0.
- Vector hold-off and lower bits:
  - Capture bus_d=16'o000107 -> vec='o104.
  - With vec_valid=1 and BR4 pending, no BG until vec_ack pulses.
- Reset/INIT mid-operation:
  - Assert bus_init during STROBE -> SSYN, BG and vec_valid all 0 the next edge.
  - Pull reset low during GRANT -> bus_bg_out=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/unibus_intr_if.sv
// Unibus interrupt-arbitration signal bundle: BR/BG, SACK/BBSY/INTR handshake, data and SSYN.
// master is the processor-side arbiter, slave is the requesting device side.
interface unibus_intr_if;
  logic [7:4] bus_br;
  logic       bus_sack;
  logic       bus_bbsy;
  logic       bus_intr;
  logic [15:0] bus_d;
  logic [7:4] bus_bg_out;
  logic       bus_ssyn_out;

  modport master (
    input  bus_br, bus_sack, bus_bbsy, bus_intr, bus_d,
    output bus_bg_out, bus_ssyn_out
  );

  modport slave (
    output bus_br, bus_sack, bus_bbsy, bus_intr, bus_d,
    input  bus_bg_out, bus_ssyn_out
  );
endinterface

// File: rtl/unibus_intr_arb.sv
// Processor-side Unibus BR/BG interrupt arbiter: deskews requests, grants one level,
// runs the SACK/INTR handshake and hands the captured vector to the CPU.
module unibus_intr_arb #(
  parameter int unsigned DESKEW    = 2,
  parameter int unsigned SSYN_DLY  = 8,
  parameter int unsigned GRANT_TMO = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_init,
  unibus_intr_if.master bus,
  input  logic [2:0]  cpu_pri,
  input  logic        grant_ok,
  output logic        vec_valid,
  output logic [15:0] vec,
  output logic [2:0]  vec_pri,
  input  logic        vec_ack
);

  localparam int unsigned DW = (DESKEW > 1)    ? $clog2(DESKEW + 1)    : 1;
  localparam int unsigned TW = (GRANT_TMO > 1) ? $clog2(GRANT_TMO + 1) : 1;
  localparam int unsigned SW = (SSYN_DLY > 1)  ? $clog2(SSYN_DLY + 1)  : 1;

  typedef enum logic [2:0] {IDLE, GRANT, WAIT_INTR, STROBE, HOLD} state_t;

  state_t        state, state_nxt;
  logic [2:0]    win;
  logic [2:0]    cand, cand_nxt;
  logic [2:0]    lvl, lvl_nxt;
  logic [DW-1:0] dsk, dsk_nxt;
  logic [TW-1:0] tmo, tmo_nxt, tmo_inc;
  logic [SW-1:0] dly, dly_nxt, dly_inc;
  logic          vv_nxt;
  logic [15:0]   vec_nxt;
  logic [2:0]    vpri_nxt;

  // Fixed priority, BR7 highest; a level must exceed the processor priority.
  always_comb begin
    win = 3'd0;
    if      (bus.bus_br[7] && cpu_pri < 3'd7) win = 3'd7;
    else if (bus.bus_br[6] && cpu_pri < 3'd6) win = 3'd6;
    else if (bus.bus_br[5] && cpu_pri < 3'd5) win = 3'd5;
    else if (bus.bus_br[4] && cpu_pri < 3'd4) win = 3'd4;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cand      <= '0;
      lvl       <= '0;
      dsk       <= '0;
      tmo       <= '0;
      dly       <= '0;
      vec_valid <= 1'b0;
      vec       <= '0;
      vec_pri   <= '0;
    end else if (bus_init) begin
      state     <= IDLE;
      cand      <= '0;
      lvl       <= '0;
      dsk       <= '0;
      tmo       <= '0;
      dly       <= '0;
      vec_valid <= 1'b0;
      vec       <= '0;
      vec_pri   <= '0;
    end else begin
      state     <= state_nxt;
      cand      <= cand_nxt;
      lvl       <= lvl_nxt;
      dsk       <= dsk_nxt;
      tmo       <= tmo_nxt;
      dly       <= dly_nxt;
      vec_valid <= vv_nxt;
      vec       <= vec_nxt;
      vec_pri   <= vpri_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    lvl_nxt   = lvl;
    dsk_nxt   = dsk;
    tmo_nxt   = tmo;
    dly_nxt   = dly;
    tmo_inc   = tmo + 1'b1;
    dly_inc   = dly + 1'b1;
    vv_nxt    = vec_valid & ~vec_ack;
    vec_nxt   = vec;
    vpri_nxt  = vec_pri;

    case (state)
      IDLE: begin
        // dsk is the run length of cand, saturating at DESKEW
        cand_nxt = win;
        if (win == 3'd0)
          dsk_nxt = '0;
        else if (win != cand)
          dsk_nxt = DW'(1);
        else if (dsk != DW'(DESKEW))
          dsk_nxt = dsk + 1'b1;
        if (win != 3'd0 && win == cand && dsk == DW'(DESKEW) && grant_ok && !vec_valid) begin
          state_nxt = GRANT;
          lvl_nxt   = win;
          cand_nxt  = '0;
          dsk_nxt   = '0;
          tmo_nxt   = '0;
        end
      end

      GRANT: begin
        if (bus.bus_sack) begin
          state_nxt = WAIT_INTR;
          tmo_nxt   = '0;
        end else if (tmo_inc == TW'(GRANT_TMO)) begin
          state_nxt = IDLE;
          tmo_nxt   = '0;
        end else begin
          tmo_nxt = tmo_inc;
        end
      end

      WAIT_INTR: begin
        if (bus.bus_intr) begin
          state_nxt = STROBE;
          dly_nxt   = '0;
          tmo_nxt   = '0;
        end else if (!bus.bus_sack && !bus.bus_bbsy) begin
          if (tmo_inc == TW'(GRANT_TMO)) begin
            state_nxt = IDLE;
            tmo_nxt   = '0;
          end else begin
            tmo_nxt = tmo_inc;
          end
        end else begin
          tmo_nxt = '0;
        end
      end

      STROBE: begin
        if (!bus.bus_intr) begin
          state_nxt = IDLE;
          dly_nxt   = '0;
        end else if (dly_inc == SW'(SSYN_DLY)) begin
          state_nxt = HOLD;
          dly_nxt   = '0;
          vv_nxt    = 1'b1;
          vec_nxt   = bus.bus_d & 16'hFFFC;
          vpri_nxt  = lvl;
        end else begin
          dly_nxt = dly_inc;
        end
      end

      HOLD: begin
        if (!bus.bus_intr) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Grant and SSYN decode from disjoint states, so they can never overlap.
  always_comb begin
    bus.bus_bg_out   = (state == GRANT) ? (4'b0001 << (lvl - 3'd4)) : 4'b0000;
    bus.bus_ssyn_out = (state == HOLD);
  end

endmodule

// File: tb/tb_unibus_intr_arb.sv
// Bench for unibus_intr_arb: directed scenarios plus randomized device/CPU traffic,
// every cycle checked against a history-based behavioural model.
module tb_unibus_intr_arb;
  localparam int DESKEW    = 2;
  localparam int SSYN_DLY  = 8;
  localparam int GRANT_TMO = 255;

  localparam int PH_IDLE = 0, PH_GRANT = 1, PH_WAIT = 2, PH_STROBE = 3, PH_HOLD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        bus_init = 1'b0;
  logic [2:0]  cpu_pri = 3'd0;
  logic        grant_ok = 1'b0;
  logic        vec_ack = 1'b0;
  logic        vec_valid;
  logic [15:0] vec;
  logic [2:0]  vec_pri;

  unibus_intr_if ub();

  unibus_intr_arb #(.DESKEW(DESKEW), .SSYN_DLY(SSYN_DLY), .GRANT_TMO(GRANT_TMO)) dut (
    .clk(clk), .reset(reset), .bus_init(bus_init), .bus(ub),
    .cpu_pri(cpu_pri), .grant_ok(grant_ok), .vec_valid(vec_valid),
    .vec(vec), .vec_pri(vec_pri), .vec_ack(vec_ack)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: winner history for deskew, elapsed-cycle counts per phase.
  int          m_phase;
  int          m_lvl;
  int          m_el;
  int          hist[$];
  bit          m_vv;
  logic [15:0] m_vec;
  int          m_vpri;

  task automatic model_reset();
    m_phase = PH_IDLE; m_lvl = 0; m_el = 0; hist.delete();
    m_vv = 0; m_vec = '0; m_vpri = 0;
  endtask

  function automatic int winner();
    int brv = int'(ub.bus_br);
    for (int n = 3; n >= 0; n--)
      if (((brv >> n) & 1) == 1 && n + 4 > int'(cpu_pri)) return n + 4;
    return 0;
  endfunction

  task automatic model_step();
    int w;
    bit stable;
    bit vv_old;
    if (!reset || bus_init) begin model_reset(); return; end
    vv_old = m_vv;
    if (vec_ack) m_vv = 0;
    case (m_phase)
      PH_IDLE: begin
        w = winner();
        hist.push_back(w);
        if (hist.size() > DESKEW + 1) void'(hist.pop_front());
        stable = (w != 0) && (hist.size() == DESKEW + 1);
        foreach (hist[i]) if (hist[i] != w) stable = 0;
        if (stable && grant_ok && !vv_old) begin
          m_phase = PH_GRANT; m_lvl = w; m_el = 0; hist.delete();
        end
      end
      PH_GRANT: begin
        if (ub.bus_sack) begin m_phase = PH_WAIT; m_el = 0; end
        else begin
          m_el++;
          if (m_el == GRANT_TMO) m_phase = PH_IDLE;
        end
      end
      PH_WAIT: begin
        if (ub.bus_intr) begin m_phase = PH_STROBE; m_el = 0; end
        else if (!ub.bus_sack && !ub.bus_bbsy) begin
          m_el++;
          if (m_el == GRANT_TMO) m_phase = PH_IDLE;
        end else m_el = 0;
      end
      PH_STROBE: begin
        if (!ub.bus_intr) m_phase = PH_IDLE;
        else begin
          m_el++;
          if (m_el == SSYN_DLY) begin
            m_phase = PH_HOLD; m_vv = 1; m_vpri = m_lvl;
            m_vec = {ub.bus_d[15:2], 2'b00};
          end
        end
      end
      default: if (!ub.bus_intr) m_phase = PH_IDLE;
    endcase
  endtask

  task automatic check_outputs();
    logic [3:0] exp_bg;
    exp_bg = (m_phase == PH_GRANT) ? 4'(1 << (m_lvl - 4)) : 4'b0000;
    check("bg", ub.bus_bg_out, exp_bg);
    check("ssyn", ub.bus_ssyn_out, m_phase == PH_HOLD);
    check("vec_valid", vec_valid, m_vv);
    check("vec", vec, m_vec);
    check("vec_pri", vec_pri, m_vpri);
    check("bg_onehot", $onehot0(ub.bus_bg_out), 1);
    check("bg_ssyn_excl", (ub.bus_bg_out != 0) && ub.bus_ssyn_out, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic wait_bg(input int budget);
    for (int i = 0; i < budget && ub.bus_bg_out == 4'b0000; i++) tick();
  endtask

  task automatic serve(input logic [15:0] d);
    ub.bus_sack = 1'b1; tick();
    ub.bus_sack = 1'b0; ub.bus_bbsy = 1'b1; ub.bus_intr = 1'b1; ub.bus_d = d;
    for (int i = 0; i <= SSYN_DLY; i++) tick();
    ub.bus_intr = 1'b0; ub.bus_bbsy = 1'b0; tick();
  endtask

  task automatic ack();
    vec_ack = 1'b1; tick(); vec_ack = 1'b0;
  endtask

  // Random device agent state
  int dev = 0;
  int dcnt = 0;

  task automatic rand_cycle();
    if ($urandom_range(0, 15) == 0) ub.bus_br = 4'($urandom);
    if ($urandom_range(0, 31) == 0) cpu_pri = 3'($urandom);
    grant_ok = ($urandom_range(0, 7) != 0);
    vec_ack  = (vec_valid && $urandom_range(0, 5) == 0) || ($urandom_range(0, 40) == 0);
    bus_init = ($urandom_range(0, 699) == 0);
    case (dev)
      0: if (ub.bus_bg_out != 4'b0000) begin
        dev = 1;
        dcnt = ($urandom_range(0, 15) == 0) ? 300 : int'($urandom_range(0, 4));
      end
      1: if (dcnt == 0) begin
        ub.bus_sack = 1'b1; dev = 2; dcnt = $urandom_range(0, 4);
      end else dcnt--;
      2: if (dcnt == 0) begin
        ub.bus_sack = 1'b0;
        if ($urandom_range(0, 9) == 0) dev = 0;
        else begin
          ub.bus_bbsy = 1'b1; ub.bus_intr = 1'b1; ub.bus_d = 16'($urandom);
          dev = 3; dcnt = $urandom_range(3, 14);
        end
      end else dcnt--;
      default: begin
        if (dcnt > 0) dcnt--;
        if (dcnt == 0 || (ub.bus_ssyn_out && $urandom_range(0, 2) == 0)) begin
          ub.bus_intr = 1'b0; ub.bus_bbsy = 1'b0; dev = 0;
        end
      end
    endcase
  endtask

  int  len;
  bit  seen;

  initial begin
    ub.bus_br = '0; ub.bus_sack = 1'b0; ub.bus_bbsy = 1'b0;
    ub.bus_intr = 1'b0; ub.bus_d = '0;
    model_reset();
    tick(); tick();
    check("rst_bg", ub.bus_bg_out, 4'b0000);
    check("rst_vv", vec_valid, 1'b0);
    reset = 1'b1;
    tick();

    // Basic BR6 interrupt
    cpu_pri = 3'd0; grant_ok = 1'b1; ub.bus_br = 4'b0100;
    tick(); tick();
    check("basic_bg_early", ub.bus_bg_out, 4'b0000);
    tick();
    check("basic_bg", ub.bus_bg_out, 4'b0100);
    ub.bus_sack = 1'b1; tick();
    check("basic_bg_drop", ub.bus_bg_out, 4'b0000);
    ub.bus_sack = 1'b0; ub.bus_bbsy = 1'b1; ub.bus_intr = 1'b1; ub.bus_d = 16'o100;
    ub.bus_br = 4'b0000;
    for (int i = 0; i < SSYN_DLY; i++) tick();
    check("basic_ssyn_early", ub.bus_ssyn_out, 1'b0);
    tick();
    check("basic_ssyn", ub.bus_ssyn_out, 1'b1);
    check("basic_vec", vec, 16'o100);
    check("basic_vpri", vec_pri, 3'd6);
    check("basic_vv", vec_valid, 1'b1);
    ub.bus_intr = 1'b0; ub.bus_bbsy = 1'b0; tick();
    check("basic_ssyn_drop", ub.bus_ssyn_out, 1'b0);
    ack();
    check("basic_ack", vec_valid, 1'b0);

    // Priority masking
    cpu_pri = 3'd6; ub.bus_br = 4'b0100; seen = 0;
    for (int i = 0; i < 1000; i++) begin tick(); seen |= (ub.bus_bg_out != 0); end
    check("mask_nogrant", seen, 1'b0);
    ub.bus_br = 4'b1100;
    wait_bg(10);
    check("mask_bg7", ub.bus_bg_out, 4'b1000);
    ub.bus_br = 4'b0000;
    serve(16'o060);
    check("mask_vpri", vec_pri, 3'd7);
    ack();

    // Simultaneous BR6 and BR4
    cpu_pri = 3'd3; ub.bus_br = 4'b0101;
    wait_bg(10);
    check("simul_bg6", ub.bus_bg_out, 4'b0100);
    ub.bus_br = 4'b0001;
    serve(16'o200);
    check("simul_vpri6", vec_pri, 3'd6);
    seen = 0;
    for (int i = 0; i < 20; i++) begin tick(); seen |= (ub.bus_bg_out != 0); end
    check("simul_holdoff", seen, 1'b0);
    ack();
    wait_bg(10);
    check("simul_bg4", ub.bus_bg_out, 4'b0001);
    serve(16'o107);
    check("lowbits_vec", vec, 16'o104);
    check("lowbits_vpri", vec_pri, 3'd4);
    ub.bus_br = 4'b0000;
    ack();
    tick();

    // Grant timeout on BR5
    cpu_pri = 3'd0; ub.bus_br = 4'b0010;
    wait_bg(10);
    check("tmo_bg5", ub.bus_bg_out, 4'b0010);
    len = 1;
    for (int i = 0; i < 400 && ub.bus_bg_out == 4'b0010; i++) begin
      tick();
      if (ub.bus_bg_out == 4'b0010) len++;
    end
    ub.bus_br = 4'b0000;
    check("tmo_len", len, GRANT_TMO);
    check("tmo_vv", vec_valid, 1'b0);
    tick(); tick(); tick(); tick();

    // bus_init during STROBE
    ub.bus_br = 4'b1000;
    wait_bg(10);
    ub.bus_sack = 1'b1; tick();
    ub.bus_sack = 1'b0; ub.bus_bbsy = 1'b1; ub.bus_intr = 1'b1; ub.bus_d = 16'o340;
    tick(); tick(); tick();
    bus_init = 1'b1; tick();
    check("init_ssyn", ub.bus_ssyn_out, 1'b0);
    check("init_bg", ub.bus_bg_out, 4'b0000);
    check("init_vv", vec_valid, 1'b0);
    bus_init = 1'b0; ub.bus_intr = 1'b0; ub.bus_bbsy = 1'b0;
    tick();

    // Asynchronous reset during GRANT
    wait_bg(10);
    check("arst_pre", ub.bus_bg_out, 4'b1000);
    #2 reset = 1'b0;
    #1 check("arst_bg", ub.bus_bg_out, 4'b0000);
    model_reset();
    tick();
    reset = 1'b1; ub.bus_br = 4'b0000;
    tick();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rand_cycle();
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
